// File: rtl/datacache_line_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : datacache_line_adapter
//  Description : Bridge between the L1 data cache and the memory-side bus.
//                Combinational word path (word <-> line steering and
//                byte-enable expansion) plus a burst engine that moves whole
//                lines as LINE_W/BEAT_W beats under a per-beat handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module datacache_line_adapter #(
   parameter int LINE_W = 256,
   parameter int WORD_W = 32,
   parameter int BEAT_W = 64,
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // word path
   input  logic [ADDR_W-1:0]     word_addr,
   input  logic [WORD_W-1:0]     word_wdata,
   input  logic [WORD_W/8-1:0]   word_be,
   input  logic [LINE_W-1:0]     line_data_in,
   output logic [LINE_W-1:0]     word_wdata_line,
   output logic [LINE_W/8-1:0]   word_be_line,
   output logic [WORD_W-1:0]     word_rdata,
   // cache-side line requests
   input  logic                  line_read,
   input  logic                  line_write,
   input  logic [ADDR_W-1:0]     line_addr,
   input  logic [LINE_W-1:0]     line_wdata,
   output logic [LINE_W-1:0]     line_rdata,
   output logic                  line_resp,
   // memory-side burst port
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [BEAT_W-1:0]     mem_wdata,
   input  logic [BEAT_W-1:0]     mem_rdata,
   input  logic                  mem_resp
);

   localparam int BEATS  = LINE_W / BEAT_W;
   localparam int WPL    = LINE_W / WORD_W;
   localparam int WBYTES = WORD_W / 8;
   localparam int LBYTES = LINE_W / 8;
   localparam int OFF    = $clog2(LBYTES);
   localparam int WB     = $clog2(WBYTES);
   localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam bit LINE_POW2 = (LINE_W >= 8) && ((LINE_W & (LINE_W - 1)) == 0);
   localparam bit WORD_POW2 = (WORD_W >= 8) && ((WORD_W & (WORD_W - 1)) == 0);
   localparam bit BEAT_POW2 = (BEAT_W >= 8) && ((BEAT_W & (BEAT_W - 1)) == 0);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------------
   if (!LINE_POW2 || !WORD_POW2 || !BEAT_POW2) begin : g_err_pow2
      $error("datacache_line_adapter: LINE_W, WORD_W and BEAT_W must be powers of two (>= 8)");
   end
   if ((LINE_W % BEAT_W) != 0) begin : g_err_beat_div
      $error("datacache_line_adapter: LINE_W must be a multiple of BEAT_W");
   end
   if (BEATS < 2) begin : g_err_beats
      $error("datacache_line_adapter: a line must span at least two beats");
   end
   if ((LINE_W % WORD_W) != 0) begin : g_err_word_div
      $error("datacache_line_adapter: LINE_W must be a multiple of WORD_W");
   end
   if (ADDR_W <= OFF) begin : g_err_addr
      $error("datacache_line_adapter: ADDR_W must exceed the line offset width");
   end

   // Address bits outside the word-slot / line-tag fields are intentionally
   // not consumed; fold them into one sink so the intent is explicit.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{word_addr, line_addr};

   // ------------------------------------------------------------------------
   // Word path (purely combinational, independent of the burst engine)
   // ------------------------------------------------------------------------
   assign word_wdata_line = {WPL{word_wdata}};

   if (WPL > 1) begin : g_multi_word
      logic [OFF-WB-1:0] slot;
      assign slot         = word_addr[OFF-1:WB];
      assign word_rdata   = line_data_in[int'(slot)*WORD_W +: WORD_W];
      assign word_be_line = {{(LBYTES-WBYTES){1'b0}}, word_be} << (int'(slot)*WBYTES);
   end else begin : g_single_word
      assign word_rdata   = line_data_in;
      assign word_be_line = word_be;
   end

   // ------------------------------------------------------------------------
   // Burst engine
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [LINE_W-1:0]      line_buf;
   logic [ADDR_W-OFF-1:0]  addr_hi;
   logic                   last_beat;

   assign last_beat  = (cnt == CW'(BEATS - 1));

   // Memory sees the latched line address with the offset forced to zero;
   // the write beat is whatever slice the beat counter points at, so it
   // naturally holds across response gaps.
   assign mem_addr   = {addr_hi, {OFF{1'b0}}};
   assign mem_wdata  = line_buf[int'(cnt)*BEAT_W +: BEAT_W];
   assign line_rdata = line_buf;

   // Sequence one line transfer; mem_read/mem_write/line_resp are registered
   // so none of them depends combinationally on mem_resp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         line_buf  <= '0;
         addr_hi   <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         line_resp <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // write-back wins when both requests arrive together
               if (line_write) begin
                  line_buf  <= line_wdata;
                  addr_hi   <= line_addr[ADDR_W-1:OFF];
                  cnt       <= '0;
                  mem_write <= 1'b1;
                  state     <= WR;
               end else if (line_read) begin
                  addr_hi   <= line_addr[ADDR_W-1:OFF];
                  cnt       <= '0;
                  mem_read  <= 1'b1;
                  state     <= RD;
               end
            end
            RD: begin
               if (mem_resp) begin
                  line_buf[int'(cnt)*BEAT_W +: BEAT_W] <= mem_rdata;
                  if (last_beat) begin
                     cnt       <= '0;
                     mem_read  <= 1'b0;
                     line_resp <= 1'b1;
                     state     <= DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            WR: begin
               if (mem_resp) begin
                  if (last_beat) begin
                     cnt       <= '0;
                     mem_write <= 1'b0;
                     line_resp <= 1'b1;
                     state     <= DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               line_resp <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_datacache_line_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datacache_line_adapter
//  Description : Self-checking bench. Two adapter instances (256/64 and
//                512/128, both four beats per line) run in lockstep against
//                a behavioural model of line transfers and word steering.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_datacache_line_adapter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // shared stimulus (instance A sees the low slices)
   logic [31:0]  word_addr;
   logic [31:0]  word_wdata;
   logic [3:0]   word_be;
   logic [511:0] line_data;
   logic         line_read;
   logic         line_write;
   logic [31:0]  line_addr;
   logic [511:0] wdata_big;
   logic [127:0] rbeat;
   logic         mem_resp;

   // instance A: LINE_W=256, BEAT_W=64
   logic [255:0] a_wdata_line;
   logic [31:0]  a_be_line;
   logic [31:0]  a_word_rdata;
   logic [255:0] a_line_rdata;
   logic         a_line_resp, a_mem_read, a_mem_write;
   logic [31:0]  a_mem_addr;
   logic [63:0]  a_mem_wdata;

   // instance B: LINE_W=512, BEAT_W=128
   logic [511:0] b_wdata_line;
   logic [63:0]  b_be_line;
   logic [31:0]  b_word_rdata;
   logic [511:0] b_line_rdata;
   logic         b_line_resp, b_mem_read, b_mem_write;
   logic [31:0]  b_mem_addr;
   logic [127:0] b_mem_wdata;

   int n_cmp = 0;
   int n_err = 0;

   datacache_line_adapter #(.LINE_W(256), .WORD_W(32), .BEAT_W(64), .ADDR_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .word_addr(word_addr), .word_wdata(word_wdata), .word_be(word_be),
      .line_data_in(line_data[255:0]),
      .word_wdata_line(a_wdata_line), .word_be_line(a_be_line), .word_rdata(a_word_rdata),
      .line_read(line_read), .line_write(line_write), .line_addr(line_addr),
      .line_wdata(wdata_big[255:0]), .line_rdata(a_line_rdata), .line_resp(a_line_resp),
      .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(rbeat[63:0]), .mem_resp(mem_resp)
   );

   datacache_line_adapter #(.LINE_W(512), .WORD_W(32), .BEAT_W(128), .ADDR_W(32)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .word_addr(word_addr), .word_wdata(word_wdata), .word_be(word_be),
      .line_data_in(line_data),
      .word_wdata_line(b_wdata_line), .word_be_line(b_be_line), .word_rdata(b_word_rdata),
      .line_read(line_read), .line_write(line_write), .line_addr(line_addr),
      .line_wdata(wdata_big), .line_rdata(b_line_rdata), .line_resp(b_line_resp),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(rbeat), .mem_resp(mem_resp)
   );

   function automatic logic [511:0] rand512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({a_mem_read, a_mem_write, a_line_resp, b_mem_read, b_mem_write, b_line_resp} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {a_mem_read, a_mem_write, a_line_resp, b_mem_read, b_mem_write, b_line_resp});
      end
      n_cmp++;
      if (a_mem_addr !== 32'h0 || b_mem_addr !== 32'h0 || a_mem_wdata !== 64'h0 || b_mem_wdata !== 128'h0) begin
         n_err++;
         $display("FAIL reset_mem: addr %h/%h wdata %h/%h want all zero", a_mem_addr, b_mem_addr, a_mem_wdata, b_mem_wdata);
      end
      n_cmp++;
      if (a_line_rdata !== 256'h0 || b_line_rdata !== 512'h0) begin
         n_err++;
         $display("FAIL reset_line_rdata: got nonzero line data, want zero");
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_word_path();
      logic [63:0]  exp_be_a, exp_be_b;
      logic [511:0] exp_wl;
      logic [31:0]  exp_rd_a, exp_rd_b;
      int           slot_a, slot_b;
      // directed case
      word_addr  = 32'h14;
      word_be    = 4'b0011;
      word_wdata = $urandom;
      line_data  = rand512();
      #1;
      n_cmp++;
      if (a_be_line !== 32'h0030_0000 || b_be_line !== 64'h0000_0000_0030_0000) begin
         n_err++;
         $display("FAIL word_be_dir: got %h/%h want 00300000/0000000000300000", a_be_line, b_be_line);
      end
      n_cmp++;
      if (a_word_rdata !== line_data[191:160] || b_word_rdata !== line_data[191:160]) begin
         n_err++;
         $display("FAIL word_rdata_dir: got %h/%h want %h", a_word_rdata, b_word_rdata, line_data[191:160]);
      end
      n_cmp++;
      if (a_wdata_line !== {8{word_wdata}}) begin
         n_err++;
         $display("FAIL word_wdata_line_dir: got %h want 8 copies of %h", a_wdata_line, word_wdata);
      end
      // randomized cases against a byte-level model
      for (int t = 0; t < 24; t++) begin
         word_addr  = $urandom;
         word_be    = 4'($urandom);
         word_wdata = $urandom;
         line_data  = rand512();
         slot_a = int'(word_addr % 32) / 4;
         slot_b = int'(word_addr % 64) / 4;
         exp_be_a = '0;
         exp_be_b = '0;
         for (int i = 0; i < 64; i++) begin
            if (i < 32 && i / 4 == slot_a) exp_be_a[i] = word_be[i % 4];
            if (i / 4 == slot_b)           exp_be_b[i] = word_be[i % 4];
         end
         for (int k = 0; k < 16; k++) exp_wl[k*32 +: 32] = word_wdata;
         exp_rd_a = 32'(line_data >> (slot_a * 32));
         exp_rd_b = 32'(line_data >> (slot_b * 32));
         #1;
         n_cmp++;
         if (a_be_line !== exp_be_a[31:0] || b_be_line !== exp_be_b) begin
            n_err++;
            $display("FAIL word_be_rand: addr %h be %b got %h/%h want %h/%h",
                     word_addr, word_be, a_be_line, b_be_line, exp_be_a[31:0], exp_be_b);
         end
         n_cmp++;
         if (a_word_rdata !== exp_rd_a || b_word_rdata !== exp_rd_b) begin
            n_err++;
            $display("FAIL word_rdata_rand: addr %h got %h/%h want %h/%h",
                     word_addr, a_word_rdata, b_word_rdata, exp_rd_a, exp_rd_b);
         end
         n_cmp++;
         if (a_wdata_line !== exp_wl[255:0] || b_wdata_line !== exp_wl) begin
            n_err++;
            $display("FAIL word_wdata_line_rand: wdata %h got %h", word_wdata, a_wdata_line);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   // One line transfer on both instances. mode 0: mem_resp always high,
   // 1: high on odd cycles after accept, 2: random.
   task automatic run_burst(input bit do_write, input bit do_read, input logic [31:0] addr,
                            input int mode, input string name);
      logic [255:0] exp_a;
      logic [511:0] exp_b;
      logic [2:0]   exp3;
      int           done;
      bit           finished;
      bit           is_write;
      is_write = do_write;
      wdata_big = rand512();
      exp_a = wdata_big[255:0];
      exp_b = wdata_big;
      line_write = do_write;
      line_read  = do_read;
      line_addr  = addr;
      mem_resp   = 1'b0;
      @(posedge clk);
      done = 0;
      finished = 1'b0;
      for (int c = 1; c <= 64 && !finished; c++) begin
         #1;
         exp3 = {!is_write && done < 4, is_write && done < 4, done == 4};
         n_cmp++;
         if ({a_mem_read, a_mem_write, a_line_resp} !== exp3 || {b_mem_read, b_mem_write, b_line_resp} !== exp3) begin
            n_err++;
            $display("FAIL %s ctrl c%0d: got rd/wr/resp %b/%b want %b", name, c,
                     {a_mem_read, a_mem_write, a_line_resp}, {b_mem_read, b_mem_write, b_line_resp}, exp3);
         end
         n_cmp++;
         if (a_mem_addr !== (addr & ~32'h1F) || b_mem_addr !== (addr & ~32'h3F)) begin
            n_err++;
            $display("FAIL %s mem_addr c%0d: got %h/%h want %h/%h", name, c,
                     a_mem_addr, b_mem_addr, addr & ~32'h1F, addr & ~32'h3F);
         end
         if (is_write && done < 4) begin
            n_cmp++;
            if (a_mem_wdata !== wdata_big[done*64 +: 64] || b_mem_wdata !== wdata_big[done*128 +: 128]) begin
               n_err++;
               $display("FAIL %s mem_wdata beat%0d: got %h/%h want %h/%h", name, done,
                        a_mem_wdata, b_mem_wdata, wdata_big[done*64 +: 64], wdata_big[done*128 +: 128]);
            end
         end
         if (is_write && c == 1) begin
            n_cmp++;
            if (a_line_rdata !== wdata_big[255:0] || b_line_rdata !== wdata_big) begin
               n_err++;
               $display("FAIL %s line_rdata_during_write: got %h want %h", name, a_line_rdata, wdata_big[255:0]);
            end
         end
         if (done == 4) begin
            n_cmp++;
            if (a_line_rdata !== exp_a || b_line_rdata !== exp_b) begin
               n_err++;
               $display("FAIL %s line_rdata: got %h want %h", name, a_line_rdata, exp_a);
            end
            if (mode == 0 || mode == 1) begin
               n_cmp++;
               if (a_line_resp !== 1'b1 || c != ((mode == 0) ? 5 : 8)) begin
                  n_err++;
                  $display("FAIL %s latency: line_resp at cycle %0d want %0d", name, c, (mode == 0) ? 5 : 8);
               end
            end
            line_read  = 1'b0;
            line_write = 1'b0;
            mem_resp   = 1'($urandom);
            finished   = 1'b1;
         end else begin
            mem_resp = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : 1'($urandom);
            if (mode == 0) rbeat = {16{8'(8'hA0 + done)}};
            else           rbeat = {$urandom, $urandom, $urandom, $urandom};
            if (mem_resp) begin
               if (!is_write) begin
                  exp_a[done*64 +: 64]   = rbeat[63:0];
                  exp_b[done*128 +: 128] = rbeat;
               end
               done++;
            end
         end
         @(posedge clk);
      end
      if (!finished) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s timeout: line_resp not seen within 64 cycles, beats done %0d", name, done);
         line_read  = 1'b0;
         line_write = 1'b0;
      end
      // back in IDLE: no activity, line data held, stray mem_resp ignored
      for (int k = 0; k < 2; k++) begin
         #1;
         n_cmp++;
         if ({a_mem_read, a_mem_write, a_line_resp, b_mem_read, b_mem_write, b_line_resp} !== 6'b0 ||
             a_line_rdata !== exp_a || b_line_rdata !== exp_b) begin
            n_err++;
            $display("FAIL %s idle_after k%0d: ctrl %b line %h want 000000 line %h", name, k,
                     {a_mem_read, a_mem_write, a_line_resp, b_mem_read, b_mem_write, b_line_resp}, a_line_rdata, exp_a);
         end
         mem_resp = 1'($urandom);
         @(posedge clk);
      end
      #1;
      mem_resp = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_mid_burst();
      line_read = 1'b1;
      line_addr = $urandom;
      mem_resp  = 1'b0;
      @(posedge clk);
      #1;
      line_read = 1'b0;
      mem_resp  = 1'b1;
      rbeat     = {$urandom, $urandom, $urandom, $urandom};
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (a_mem_read !== 1'b1 || b_mem_read !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid pre: mem_read %b/%b want 1/1", a_mem_read, b_mem_read);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_mem_read, a_line_resp, b_mem_read, b_line_resp} !== 4'b0 ||
          a_line_rdata !== 256'h0 || b_mem_addr !== 32'h0) begin
         n_err++;
         $display("FAIL rst_mid async: rd/resp %b addr %h want 0000 and cleared state",
                  {a_mem_read, a_line_resp, b_mem_read, b_line_resp}, b_mem_addr);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if ({a_mem_read, a_mem_write, a_line_resp, b_mem_read, b_mem_write, b_line_resp} !== 6'b0) begin
            n_err++;
            $display("FAIL rst_mid hold k%0d: got %b want 000000", k,
                     {a_mem_read, a_mem_write, a_line_resp, b_mem_read, b_mem_write, b_line_resp});
         end
      end
      @(negedge clk);
      rst_n    = 1'b1;
      mem_resp = 1'b0;
      run_burst(1'b0, 1'b1, $urandom, 2, "read_after_reset");
   endtask

   // ------------------------------------------------------------------------
   task automatic test_back_to_back();
      bit w;
      for (int t = 0; t < 6; t++) begin
         w = 1'($urandom);
         run_burst(w, !w || 1'($urandom), $urandom, 2, w ? "b2b_write" : "b2b_read");
      end
   endtask

   initial begin
      word_addr  = '0;
      word_wdata = '0;
      word_be    = '0;
      line_data  = '0;
      line_read  = 1'b0;
      line_write = 1'b0;
      line_addr  = '0;
      wdata_big  = '0;
      rbeat      = '0;
      mem_resp   = 1'b0;
      test_reset();
      test_word_path();
      run_burst(1'b0, 1'b1, 32'h1000_0047, 0, "read_burst");
      run_burst(1'b1, 1'b0, $urandom,      1, "write_burst");
      run_burst(1'b1, 1'b1, $urandom,      0, "simultaneous");
      test_reset_mid_burst();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
